// File: rtl/oh_pwr_if.sv
// Request/acknowledge and power-control bundle between a power manager and oh_pwr_ctrl.
// The master drives the request and timing configuration; the slave reports header, isolation and reset state.
interface oh_pwr_if #(
   parameter int N  = 4,
   parameter int CW = 8
);
   logic          pwr_req;
   logic [CW-1:0] stagger;
   logic [CW-1:0] settle;
   logic          pwr_ack;
   logic [N-1:0]  npower;
   logic          iso;
   logic          dom_reset;
   logic          busy;

   modport master (
      output pwr_req, stagger, settle,
      input  pwr_ack, npower, iso, dom_reset, busy
   );

   modport slave (
      input  pwr_req, stagger, settle,
      output pwr_ack, npower, iso, dom_reset, busy
   );
endinterface

// File: rtl/oh_pwr_ctrl.sv
// Power-sequencing controller for one switchable domain: staggered header turn-on,
// supply settle, isolation/reset release, and ordered power-down with drain wait.
module oh_pwr_ctrl #(
   parameter int N  = 4,
   parameter int CW = 8
) (
   input  logic     clk,
   input  logic     reset,
   oh_pwr_if.slave  pif
);
   localparam int SW = $clog2(N + 1);

   typedef enum logic [2:0] {
      S_OFF, S_RAMP, S_SETTLE, S_UNRST, S_ON, S_DOWN, S_DRAIN
   } state_t;

   state_t        state_q, state_d;
   logic [SW-1:0] seg_q, seg_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] lim_q, lim_d;
   logic [N-1:0]  npower_q, npower_d;
   logic          iso_q, iso_d;
   logic          dom_reset_q, dom_reset_d;
   logic          pwr_ack_q, pwr_ack_d;
   logic          busy_q, busy_d;
   logic          seg_step;

   // Terminal count for a wait of eff(x) cycles; a zero setting behaves as one cycle.
   function automatic logic [CW-1:0] lim_of(input logic [CW-1:0] x);
      return (x == '0) ? '0 : x - CW'(1);
   endfunction

   assign seg_step = (state_q == S_RAMP) && (seg_q != SW'(N)) && (cnt_q == lim_q);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_OFF;
         seg_q       <= '0;
         cnt_q       <= '0;
         lim_q       <= '0;
         npower_q    <= '1;
         iso_q       <= 1'b1;
         dom_reset_q <= 1'b1;
         pwr_ack_q   <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         seg_q       <= seg_d;
         cnt_q       <= cnt_d;
         lim_q       <= lim_d;
         npower_q    <= npower_d;
         iso_q       <= iso_d;
         dom_reset_q <= dom_reset_d;
         pwr_ack_q   <= pwr_ack_d;
         busy_q      <= busy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      seg_d   = seg_q;
      cnt_d   = cnt_q;
      lim_d   = lim_q;
      case (state_q)
         S_OFF: begin
            if (pif.pwr_req) begin
               state_d = S_RAMP;
               seg_d   = SW'(1);
               cnt_d   = '0;
               lim_d   = lim_of(pif.stagger);
            end
         end
         S_RAMP: begin
            // Only a single-segment header enters RAMP already complete.
            if (seg_q == SW'(N)) begin
               state_d = S_SETTLE;
               cnt_d   = '0;
               lim_d   = lim_of(pif.settle);
            end else if (seg_step) begin
               seg_d = seg_q + SW'(1);
               cnt_d = '0;
               if (seg_q + SW'(1) == SW'(N)) begin
                  state_d = S_SETTLE;
                  lim_d   = lim_of(pif.settle);
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_SETTLE: begin
            if (cnt_q == lim_q) state_d = S_UNRST;
            else                cnt_d   = cnt_q + CW'(1);
         end
         S_UNRST: state_d = S_ON;
         S_ON: begin
            if (!pif.pwr_req) state_d = S_DOWN;
         end
         S_DOWN: begin
            state_d = S_DRAIN;
            cnt_d   = '0;
            lim_d   = lim_of(pif.settle);
         end
         S_DRAIN: begin
            if (cnt_q == lim_q) state_d = S_OFF;
            else                cnt_d   = cnt_q + CW'(1);
         end
         default: state_d = S_OFF;
      endcase
   end

   always_comb begin
      npower_d    = npower_q;
      iso_d       = iso_q;
      dom_reset_d = dom_reset_q;
      pwr_ack_d   = pwr_ack_q;
      busy_d      = !((state_d == S_OFF) || (state_d == S_ON));
      case (state_q)
         S_OFF: begin
            if (state_d == S_RAMP) npower_d[0] = 1'b0;
         end
         S_RAMP: begin
            for (int k = 0; k < N; k++) begin
               if (seg_step && (seg_q == SW'(k))) npower_d[k] = 1'b0;
            end
         end
         S_SETTLE: begin
            if (state_d == S_UNRST) iso_d = 1'b0;
         end
         S_UNRST: begin
            dom_reset_d = 1'b0;
            pwr_ack_d   = 1'b1;
         end
         S_ON: begin
            // Clamp and reset the domain a full cycle before the headers open.
            if (state_d == S_DOWN) begin
               iso_d       = 1'b1;
               dom_reset_d = 1'b1;
            end
         end
         S_DOWN:  npower_d = '1;
         S_DRAIN: begin
            if (state_d == S_OFF) pwr_ack_d = 1'b0;
         end
         default: ;
      endcase
   end

   assign pif.npower    = npower_q;
   assign pif.iso       = iso_q;
   assign pif.dom_reset = dom_reset_q;
   assign pif.pwr_ack   = pwr_ack_q;
   assign pif.busy      = busy_q;
endmodule

// File: tb/tb_oh_pwr_ctrl.sv
// Self-checking bench for oh_pwr_ctrl: directed timing scenarios plus randomized
// request/config/reset traffic checked every cycle against a timeline model.
module tb_oh_pwr_ctrl;
   localparam int N  = 4;
   localparam int CW = 8;

   logic clk;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   oh_pwr_if #(.N(N), .CW(CW)) pif ();

   oh_pwr_ctrl #(.N(N), .CW(CW)) dut (
      .clk   (clk),
      .reset (reset),
      .pif   (pif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Timeline model: phase 0 off, 1 powering up, 2 on, 3 powering down;
   // t counts edges since the edge that accepted the request.
   int phase = 0;
   int t = 0;
   int s_eff = 1;
   int st_eff = 1;
   int t_iso = 0;

   function automatic int eff(input logic [CW-1:0] x);
      return (x == 0) ? 1 : int'(x);
   endfunction

   task automatic model_step();
      if (reset) begin
         phase = 0;
      end else begin
         case (phase)
            0: if (pif.pwr_req) begin
               phase  = 1;
               t      = 0;
               s_eff  = eff(pif.stagger);
               st_eff = eff(pif.settle);
               t_iso  = (N - 1) * s_eff + st_eff + ((N == 1) ? 1 : 0);
            end
            1: begin
               t++;
               if (t == t_iso + 1) phase = 2;
            end
            2: if (!pif.pwr_req) begin
               phase  = 3;
               t      = 0;
               st_eff = eff(pif.settle);
            end
            default: begin
               t++;
               if (t == 1 + st_eff) phase = 0;
            end
         endcase
      end
   endtask

   function automatic logic [N+3:0] model_out();
      logic [N-1:0] np;
      case (phase)
         0: return {{N{1'b1}}, 1'b1, 1'b1, 1'b0, 1'b0};
         1: begin
            for (int k = 0; k < N; k++) np[k] = !(t >= k * s_eff);
            return {np, !(t >= t_iso), 1'b1, 1'b0, 1'b1};
         end
         2: return {{N{1'b0}}, 1'b0, 1'b0, 1'b1, 1'b0};
         default: begin
            np = (t >= 1) ? {N{1'b1}} : {N{1'b0}};
            return {np, 1'b1, 1'b1, 1'b1, 1'b1};
         end
      endcase
   endfunction

   logic [N-1:0] prev_npower = '1;
   logic         prev_iso = 1'b1;
   logic         prev_dom = 1'b1;
   logic         rst_edge;

   always @(posedge clk) begin
      rst_edge = reset;
      model_step();
      #1;
      check_eq("outputs", {pif.npower, pif.iso, pif.dom_reset, pif.pwr_ack, pif.busy}, model_out());
      if (!pif.iso) check_eq("inv_iso_npower", pif.npower, 0);
      if (!pif.dom_reset) check_eq("inv_rst_iso", pif.iso, 0);
      if (((pif.npower & ~prev_npower) != 0) && !rst_edge)
         check_eq("inv_down_order", {prev_iso, prev_dom}, 2'b11);
      prev_npower = pif.npower;
      prev_iso    = pif.iso;
      prev_dom    = pif.dom_reset;
   end

   task automatic wait_ack(input logic val, input int budget);
      int n = 0;
      while (pif.pwr_ack !== val && n < budget) begin
         @(negedge clk);
         n++;
      end
      check_eq("wait_ack", pif.pwr_ack, val);
   endtask

   initial begin
      int n;
      reset       = 1'b1;
      pif.pwr_req = 1'b1;
      pif.stagger = 8'd2;
      pif.settle  = 8'd3;
      repeat (3) @(negedge clk);
      check_eq("rst_npower", pif.npower, 4'b1111);
      check_eq("rst_iso_dom_ack_busy", {pif.iso, pif.dom_reset, pif.pwr_ack, pif.busy}, 4'b1100);
      reset = 1'b0;

      for (int e = 1; e <= 11; e++) begin
         @(negedge clk);
         if (e == 1) check_eq("up_np_e1", pif.npower, 4'b1110);
         if (e == 3) check_eq("up_np_e3", pif.npower, 4'b1100);
         if (e == 5) check_eq("up_np_e5", pif.npower, 4'b1000);
         if (e == 7) check_eq("up_np_e7", pif.npower, 4'b0000);
         if (e == 9) check_eq("up_iso_e9", pif.iso, 1);
         if (e == 10) check_eq("up_iso_busy_e10", {pif.iso, pif.busy, pif.pwr_ack}, 3'b010);
         if (e == 11) check_eq("up_ack_e11", {pif.dom_reset, pif.pwr_ack, pif.busy}, 3'b010);
      end

      pif.pwr_req = 1'b0;
      for (int d = 0; d <= 4; d++) begin
         @(negedge clk);
         if (d == 0) check_eq("dn_iso_dom_D", {pif.iso, pif.dom_reset, pif.npower}, 6'b110000);
         if (d == 1) check_eq("dn_np_D1", pif.npower, 4'b1111);
         if (d == 3) check_eq("dn_ack_D3", pif.pwr_ack, 1);
         if (d == 4) check_eq("dn_ack_D4", pif.pwr_ack, 0);
      end

      pif.stagger = 8'd0;
      pif.settle  = 8'd0;
      pif.pwr_req = 1'b1;
      for (int e = 1; e <= 6; e++) begin
         @(negedge clk);
         if (e == 4) check_eq("zero_np_e4", pif.npower, 4'b0000);
         if (e == 5) check_eq("zero_ack_e5", {pif.iso, pif.pwr_ack}, 2'b00);
         if (e == 6) check_eq("zero_ack_e6", pif.pwr_ack, 1);
      end
      pif.pwr_req = 1'b0;
      wait_ack(1'b0, 20);

      pif.stagger = 8'd1;
      pif.settle  = 8'd2;
      pif.pwr_req = 1'b1;
      @(negedge clk);
      pif.pwr_req = 1'b0;
      wait_ack(1'b1, 40);
      @(negedge clk);
      check_eq("glitch_down_start", {pif.iso, pif.dom_reset, pif.busy}, 3'b111);
      wait_ack(1'b0, 40);
      check_eq("glitch_np_off", pif.npower, 4'b1111);

      pif.stagger = 8'd2;
      pif.settle  = 8'd3;
      pif.pwr_req = 1'b1;
      n = 0;
      while (pif.npower !== 4'b1100 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check_eq("midramp_reached", pif.npower, 4'b1100);
      reset = 1'b1;
      @(negedge clk);
      check_eq("midramp_rst", {pif.npower, pif.iso, pif.dom_reset, pif.pwr_ack, pif.busy}, 8'b11111100);
      reset       = 1'b0;
      pif.pwr_req = 1'b0;
      repeat (2) @(negedge clk);

      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         reset = ($urandom_range(0, 299) == 0);
         if (phase == 0 && $urandom_range(0, 3) == 0) begin
            pif.stagger = CW'($urandom_range(0, 3));
            pif.settle  = CW'($urandom_range(0, 4));
         end
         if ($urandom_range(0, 9) == 0) pif.pwr_req = ~pif.pwr_req;
      end
      reset = 1'b0;
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
